// File: rtl/mult_writeback.sv
// Writeback stage behind the 64x64 multiplier: captures the 128-bit product
// into HI/LO and drains it to the register file (LO first, then optional HI)
// through one write port using a request/grant handshake.
module mult_writeback #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] product,
  input  logic [ADDR_WIDTH-1:0]   rd_lo,
  input  logic [ADDR_WIDTH-1:0]   rd_hi,
  input  logic                    write_hi,
  input  logic                    rf_grant,
  output logic                    rf_wr_en,
  output logic [ADDR_WIDTH-1:0]   rf_wr_addr,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic [DATA_WIDTH-1:0]   hi_reg,
  output logic [DATA_WIDTH-1:0]   lo_reg,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [ADDR_WIDTH-1:0]   rd_lo_q, rd_lo_d, rd_hi_q, rd_hi_d;
  logic                    write_hi_q, write_hi_d;

  logic wr_req;
  logic advance;
  logic final_wr;
  logic accept;

  // Next-state, capture and handshake logic; x0 writes are skipped without
  // waiting for a grant, and a new product may enter on the final write.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rd_lo_d    = rd_lo_q;
    rd_hi_d    = rd_hi_q;
    write_hi_d = write_hi_q;
    wr_req     = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;

    case (state_q)
      WR_LO: begin
        rf_wr_addr = rd_lo_q;
        rf_wr_data = lo_q;
        wr_req     = (rd_lo_q != '0);
      end
      WR_HI: begin
        rf_wr_addr = rd_hi_q;
        rf_wr_data = hi_q;
        wr_req     = (rd_hi_q != '0);
      end
      default: ;
    endcase

    advance  = (state_q != IDLE) && (rf_grant || !wr_req);
    final_wr = advance && ((state_q == WR_HI) || !write_hi_q);
    in_ready = (state_q == IDLE) || final_wr;
    accept   = in_valid && in_ready;

    if (accept) begin
      state_d    = WR_LO;
      lo_d       = product[DATA_WIDTH-1:0];
      hi_d       = product[2*DATA_WIDTH-1:DATA_WIDTH];
      rd_lo_d    = rd_lo;
      rd_hi_d    = rd_hi;
      write_hi_d = write_hi;
    end else if (final_wr) begin
      state_d = IDLE;
    end else if (advance) begin
      state_d = WR_HI;
    end

    // A reset cycle abandons the drain, so no write or completion escapes it.
    rf_wr_en = wr_req && !reset;
    done     = final_wr && !reset;
    busy     = (state_q != IDLE);
    hi_reg   = hi_q;
    lo_reg   = lo_q;
  end

  // State and captured-product registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      rd_lo_q    <= '0;
      rd_hi_q    <= '0;
      write_hi_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rd_lo_q    <= rd_lo_d;
      rd_hi_q    <= rd_hi_d;
      write_hi_q <= write_hi_d;
    end
  end

endmodule

// File: tb/tb_mult_writeback.sv
// Self-checking bench for mult_writeback: directed vector table covering the
// main sequences, then random traffic checked against a queue-based model.
module tb_mult_writeback;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] product;
  logic [4:0]   rd_lo, rd_hi;
  logic         write_hi;
  logic         rf_grant;
  logic         rf_wr_en;
  logic [4:0]   rf_wr_addr;
  logic [63:0]  rf_wr_data;
  logic [63:0]  hi_reg, lo_reg;
  logic         busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_writeback #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .rd_lo(rd_lo), .rd_hi(rd_hi), .write_hi(write_hi),
    .rf_grant(rf_grant), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .hi_reg(hi_reg), .lo_reg(lo_reg),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic         rst, vld;
    logic [127:0] prod;
    logic [4:0]   rl, rh;
    logic         wh, gnt;
    logic         en, chk_ad;
    logic [4:0]   addr;
    logic [63:0]  data;
    logic         dn, rdy, bsy;
    logic [63:0]  hi, lo;
  } vec_t;

  function automatic vec_t mk(input logic rst, vld, input logic [127:0] prod,
                              input logic [4:0] rl, rh, input logic wh, gnt,
                              input logic en, chk_ad, input logic [4:0] addr,
                              input logic [63:0] data, input logic dn, rdy, bsy,
                              input logic [63:0] hi, lo);
    vec_t v;
    v.rst = rst; v.vld = vld; v.prod = prod; v.rl = rl; v.rh = rh; v.wh = wh;
    v.gnt = gnt; v.en = en; v.chk_ad = chk_ad; v.addr = addr; v.data = data;
    v.dn = dn; v.rdy = rdy; v.bsy = bsy; v.hi = hi; v.lo = lo;
    return v;
  endfunction

  localparam logic [63:0] M2   = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] DB   = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] AAAA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] S555 = 64'h5555_5555_5555_5555;

  // Reference model: list of pending register-file writes plus HI/LO.
  typedef struct { logic [4:0] addr; logic [63:0] data; } wr_t;
  wr_t         q[$];
  logic [63:0] m_hi, m_lo;

  vec_t vt[$];

  initial begin
    reset = 1'b1; in_valid = 1'b0; product = '0; rd_lo = '0; rd_hi = '0;
    write_hi = 1'b0; rf_grant = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // rst vld prod rl rh wh gnt | en chk_ad addr data dn rdy bsy hi lo
    vt.push_back(mk(0,1,{64'h2,M2},3,4,1,1,   0,1,0,0,        0,1,0, 0,0));
    vt.push_back(mk(0,0,'0,0,0,0,1,           1,1,3,M2,       0,0,1, 64'h2,M2));
    vt.push_back(mk(0,0,'0,0,0,0,1,           1,1,4,64'h2,    1,1,1, 64'h2,M2));
    vt.push_back(mk(0,0,'0,0,0,0,1,           0,0,0,0,        0,1,0, 64'h2,M2));
    vt.push_back(mk(0,1,{DB,64'h15},7,12,0,1, 0,0,0,0,        0,1,0, 64'h2,M2));
    vt.push_back(mk(0,0,'0,0,0,0,1,           1,1,7,64'h15,   1,1,1, DB,64'h15));
    vt.push_back(mk(0,0,'0,0,0,0,1,           0,0,0,0,        0,1,0, DB,64'h15));
    vt.push_back(mk(0,1,{AAAA,S555},10,11,1,0,0,0,0,0,        0,1,0, DB,64'h15));
    vt.push_back(mk(0,1,{64'h1,64'h1},1,1,0,0,1,1,10,S555,    0,0,1, AAAA,S555));
    vt.push_back(mk(0,0,'0,0,0,0,0,           1,1,10,S555,    0,0,1, AAAA,S555));
    vt.push_back(mk(0,0,'0,0,0,0,0,           1,1,10,S555,    0,0,1, AAAA,S555));
    vt.push_back(mk(0,0,'0,0,0,0,1,           1,1,10,S555,    0,0,1, AAAA,S555));
    vt.push_back(mk(0,1,{64'h1234,64'h777},5,6,0,1, 1,1,11,AAAA, 1,1,1, AAAA,S555));
    vt.push_back(mk(0,0,'0,0,0,0,1,           1,1,5,64'h777,  1,1,1, 64'h1234,64'h777));
    vt.push_back(mk(0,1,{64'h99,64'h88},0,9,1,0, 0,0,0,0,     0,1,0, 64'h1234,64'h777));
    vt.push_back(mk(0,0,'0,0,0,0,0,           0,1,0,64'h88,   0,0,1, 64'h99,64'h88));
    vt.push_back(mk(0,0,'0,0,0,0,1,           1,1,9,64'h99,   1,1,1, 64'h99,64'h88));
    vt.push_back(mk(0,1,{64'h77,64'h66},2,3,1,1, 0,0,0,0,     0,1,0, 64'h99,64'h88));
    vt.push_back(mk(1,1,{64'h5,64'h6},8,8,1,1,0,0,0,0,        0,0,1, 64'h77,64'h66));
    vt.push_back(mk(0,0,'0,0,0,0,1,           0,0,0,0,        0,1,0, 0,0));
    vt.push_back(mk(0,0,'0,0,0,0,1,           0,0,0,0,        0,1,0, 0,0));

    for (int i = 0; i < vt.size(); i++) begin
      reset = vt[i].rst; in_valid = vt[i].vld; product = vt[i].prod;
      rd_lo = vt[i].rl; rd_hi = vt[i].rh; write_hi = vt[i].wh; rf_grant = vt[i].gnt;
      @(negedge clk);
      chk($sformatf("v%0d.wr_en", i), 64'(rf_wr_en), 64'(vt[i].en));
      if (vt[i].chk_ad) begin
        chk($sformatf("v%0d.addr", i), 64'(rf_wr_addr), 64'(vt[i].addr));
        chk($sformatf("v%0d.data", i), rf_wr_data, vt[i].data);
      end
      chk($sformatf("v%0d.done", i), 64'(done), 64'(vt[i].dn));
      chk($sformatf("v%0d.in_ready", i), 64'(in_ready), 64'(vt[i].rdy));
      chk($sformatf("v%0d.busy", i), 64'(busy), 64'(vt[i].bsy));
      chk($sformatf("v%0d.hi_reg", i), hi_reg, vt[i].hi);
      chk($sformatf("v%0d.lo_reg", i), lo_reg, vt[i].lo);
      @(posedge clk); #1;
    end

    // Random traffic against the pending-write model (DUT is idle, HI/LO zero).
    m_hi = '0; m_lo = '0; q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic e_busy, e_final, e_ready, adv;
      reset    = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 1) == 1);
      product  = {$urandom, $urandom, $urandom, $urandom};
      rd_lo    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd_hi    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      write_hi = $urandom_range(0, 1);
      rf_grant = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      e_busy  = (q.size() > 0);
      adv     = e_busy && (rf_grant || q[0].addr == 5'd0);
      e_final = adv && (q.size() == 1);
      e_ready = !e_busy || e_final;
      chk("rnd.busy", 64'(busy), 64'(e_busy));
      chk("rnd.wr_en", 64'(rf_wr_en), 64'(e_busy && !reset && q[0].addr != 5'd0));
      chk("rnd.done", 64'(done), 64'(e_final && !reset));
      if (!reset) chk("rnd.in_ready", 64'(in_ready), 64'(e_ready));
      if (e_busy) begin
        chk("rnd.addr", 64'(rf_wr_addr), 64'(q[0].addr));
        chk("rnd.data", rf_wr_data, q[0].data);
      end
      chk("rnd.hi_reg", hi_reg, m_hi);
      chk("rnd.lo_reg", lo_reg, m_lo);
      if (reset) begin
        q.delete(); m_hi = '0; m_lo = '0;
      end else begin
        if (adv) void'(q.pop_front());
        if (in_valid && e_ready) begin
          m_lo = product[63:0];
          m_hi = product[127:64];
          q.push_back('{rd_lo, m_lo});
          if (write_hi) q.push_back('{rd_hi, m_hi});
        end
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_writeback.md
Name: mult_writeback

Overview:
- Sequential writeback stage directly downstream of the 64x64 signed multiplier.
- Captures the 128-bit product into architectural HI/LO registers.
- Drains the product to the register file through its single 64-bit write port: LO first, then optionally HI, over consecutive granted cycles.
- Arbitrates with the rest of the datapath via a valid/ready input handshake and a request/grant write-port handshake.

Parameters:
- DATA_WIDTH, 64, width of one register-file word; product width is 2*DATA_WIDTH.
- ADDR_WIDTH, 5, register-file address width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  product and destination fields valid this cycle.
- in_ready  output  1  stage can accept a new product this cycle.
- product  input  2*DATA_WIDTH  signed product from the multiplier.
- rd_lo  input  ADDR_WIDTH  destination register for product[DATA_WIDTH-1:0].
- rd_hi  input  ADDR_WIDTH  destination register for product[2*DATA_WIDTH-1:DATA_WIDTH].
- write_hi  input  1  1 = write both halves; 0 = LO half only.
- rf_grant  input  1  register-file write port granted this cycle.
- rf_wr_en  output  1  write request to register file.
- rf_wr_addr  output  ADDR_WIDTH  write address.
- rf_wr_data  output  DATA_WIDTH  write data.
- hi_reg  output  DATA_WIDTH  architectural HI (upper product half).
- lo_reg  output  DATA_WIDTH  architectural LO (lower product half).
- busy  output  1  a product is being drained (state != IDLE).
- done  output  1  one-cycle pulse in the cycle the final write is granted.

Behaviour:
- Reset values:
  - state = IDLE.
  - hi_reg = lo_reg = 0; captured rd_lo, rd_hi, write_hi = 0.
  - rf_wr_en = 0, rf_wr_addr = 0, rf_wr_data = 0.
  - busy = 0, done = 0.
  - in_ready = 1 on the first cycle after reset deasserts.
- States: IDLE, WR_LO, WR_HI.
- Accept: occurs when in_valid && in_ready at a clock edge.
  - lo_reg <= product[DATA_WIDTH-1:0]; hi_reg <= product[2*DATA_WIDTH-1:DATA_WIDTH].
  - Latch rd_lo, rd_hi, write_hi.
  - Next state = WR_LO.
- IDLE: in_ready = 1; rf_wr_en = 0.
- WR_LO:
  - rf_wr_addr = latched rd_lo; rf_wr_data = lo_reg.
  - rf_wr_en = 1 unless latched rd_lo == 0 (x0 writes suppressed).
  - Advances only on rf_grant, or unconditionally when the write is suppressed.
  - On advance: go to WR_HI if write_hi = 1; otherwise this is the final write.
- WR_HI: same as WR_LO, using rd_hi and hi_reg. Always the final write.
- Final write cycle (write granted or suppressed):
  - done = 1.
  - in_ready = 1, combinational on rf_grant, so a new product may be accepted in the same cycle.
  - On simultaneous accept: next state = WR_LO with the new capture; otherwise next state = IDLE.
- Stall: while rf_grant = 0 in a write state, hold state, address, data and rf_wr_en stable; in_ready = 0.
- Latency: accept at edge N → LO write presented in cycle N+1 → HI write presented in cycle N+2, both assuming continuous grant.
- Throughput: one product every 1 cycle (LO only) or 2 cycles (both halves).
- hi_reg / lo_reg:
  - Change only on accept and hold across the drain.
  - Readable at any time; reflect the most recently accepted product.
- Width: halves are copied bit-exact. The product is already two's complement, so no sign manipulation is done here.
- Outputs:
  - rf_wr_* and busy are driven from registered state and captured data.
  - in_ready and done are combinational from state and rf_grant.
- Reset mid-operation:
  - Abandons the drain; no further writes.
  - hi_reg / lo_reg clear to 0.
  - Reset takes priority over a simultaneous accept or grant.
- rd_lo == rd_hi with write_hi = 1: both writes issue in order; HI wins.

Test Plan:
- Reset, then accept product=0x0000000000000002_FFFFFFFFFFFFFFFE, rd_lo=3, rd_hi=4, write_hi=1, rf_grant=1 → cycle N+1: wr_en=1, addr=3, data=0xFFFFFFFFFFFFFFFE; cycle N+2: wr_en=1, addr=4, data=0x2, done=1; hi_reg=0x2.
- write_hi=0, rd_lo=7, product=0x…_0000000000000015 → single write addr=7, data=0x15 with done in the same cycle; no HI write; hi_reg still updated.
- rf_grant held 0 for 3 cycles during WR_LO → outputs stable, in_ready=0, busy=1; LO completes on the first grant, then HI proceeds.
- Back-to-back: second in_valid asserted during final granted write → accepted with no bubble; its LO write appears next cycle; lo_reg switches to the new value.
- rd_lo=0, rd_hi=9, write_hi=1 → WR_LO with rf_wr_en=0 and advance without grant; HI write to 9 follows next cycle.
- Reset asserted in WR_LO with a pending grant → no write that cycle or after; next cycle IDLE, hi_reg=lo_reg=0, in_ready=1.
